// File: rtl/rat_int_pkg.sv
// rat_int_pkg: shared state encoding and sizing helpers for the RAT interrupt controller.
package rat_int_pkg;
    typedef enum logic [1:0] {IDLE, REQ, SERVICE, CLEAR} int_state_t;
    localparam int DEF_N_SRC = 4;
    localparam int DEF_TIMEOUT = 64;
    function automatic int src_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    localparam int SRC_W = src_w(DEF_N_SRC);
endpackage

// File: rtl/irq_edge_latch.sv
// irq_edge_latch: registers one request line and latches its rising edge into a pending flop (set beats clear).
module irq_edge_latch (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    logic cur, prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= 1'b0;
            prev <= 1'b0;
            pending <= 1'b0;
        end else begin
            cur <= irq;
            prev <= cur;
            pending <= (cur & ~prev) | (pending & ~clr);
        end
    end
endmodule

// File: rtl/rat_int_controller.sv
// rat_int_controller: edge-captured, lowest-index-first interrupt controller with ack/EOI handshake.
// Define IRQ_TIMEOUT_EN to abandon an unacknowledged request after TIMEOUT cycles.
module rat_int_controller import rat_int_pkg::*; #(
    parameter int N_SRC = DEF_N_SRC,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_SRC-1:0]         irq_in,
    input  logic                     mask_we,
    input  logic [N_SRC-1:0]         mask_din,
    input  logic                     int_ack,
    input  logic                     eoi,
    output logic                     cpu_int,
    output logic [src_w(N_SRC)-1:0]  src_id,
    output logic [N_SRC-1:0]         pending,
    output logic                     busy,
    output logic                     timeout_flag
);
    localparam int SW = src_w(N_SRC);
    int_state_t state, state_n;
    logic [N_SRC-1:0] mask, eligible, clr;
    logic [SW-1:0] sel;
    logic tmo;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign clr[g] = state == CLEAR && src_id == SW'(g);
        irq_edge_latch u_latch (.clk(clk), .rst(rst), .irq(irq_in[g]), .clr(clr[g]), .pending(pending[g]));
    end

    assign eligible = pending & mask;
    assign cpu_int = state == REQ;
    assign busy = state != IDLE;

    // Scan high to low so the lowest eligible index is the one left in sel.
    always_comb begin
        sel = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (eligible[i]) sel = SW'(i);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |eligible ? REQ : IDLE;
            REQ:     state_n = int_ack ? SERVICE : (tmo ? IDLE : REQ);
            SERVICE: state_n = eoi ? CLEAR : SERVICE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            src_id <= '0;
            mask <= '1;
        end else begin
            state <= state_n;
            src_id <= (state == IDLE && |eligible) ? sel : src_id;
            mask <= mask_we ? mask_din : mask;
        end
    end

`ifdef IRQ_TIMEOUT_EN
    logic [7:0] cnt;
    assign tmo = state == REQ && cnt == 8'(TIMEOUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            timeout_flag <= 1'b0;
        end else begin
            cnt <= state == REQ ? cnt + 8'd1 : 8'd0;
            timeout_flag <= (tmo & ~int_ack) | (timeout_flag & ~mask_we);
        end
    end
`else
    assign tmo = 1'b0;
    assign timeout_flag = 1'(TIMEOUT < 0);
`endif
endmodule

// File: tb/tb_rat_int_controller.sv
// tb_rat_int_controller: scoreboard bench; expected source IDs are queued and popped on each cpu_int rise.
module tb_rat_int_controller;
    import rat_int_pkg::*;
    logic clk = 0, rst = 1;
    logic [3:0] irq_in = '0, mask_din = '0, pending;
    logic mask_we = 0, int_ack = 0, eoi = 0;
    logic cpu_int, busy, timeout_flag, prev_ci = 0;
    logic [SRC_W-1:0] src_id;
    int n_cmp = 0, n_err = 0;
    int exp_q[$];

    rat_int_controller #(.N_SRC(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_din(mask_din),
        .int_ack(int_ack), .eoi(eoi), .cpu_int(cpu_int), .src_id(src_id),
        .pending(pending), .busy(busy), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic serve();
        int_ack = 1;
        tick();
        int_ack = 0;
        eoi = 1;
        tick();
        eoi = 0;
        tick();
    endtask

    always @(negedge clk) begin
        if (cpu_int && !prev_ci) begin
            check("int_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("src_id", src_id, exp_q.pop_front());
        end
        prev_ci <= cpu_int;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        tick(2);
        check("rst_cpu_int", cpu_int, 0);
        check("rst_src_id", src_id, 0);
        check("rst_pending", pending, 0);
        check("rst_busy", busy, 0);
        check("rst_tflag", timeout_flag, 0);
        rst = 0;
        tick();

        // 1: long level on irq[2], late ack
        irq_in = 4'b0100;
        tick(2);
        check("t1_pending", pending, 4'b0100);
        check("t1_no_int_yet", cpu_int, 0);
        exp_q.push_back(2);
        tick();
        check("t1_cpu_int", cpu_int, 1);
        tick(3);
        int_ack = 1;
        tick();
        int_ack = 0;
        irq_in = 0;
        check("t1_service_int", cpu_int, 0);
        check("t1_service_busy", busy, 1);
        eoi = 1;
        tick();
        eoi = 0;
        check("t1_clear_pending", pending, 4'b0100);
        tick();
        check("t1_done_pending", pending, 0);
        check("t1_done_busy", busy, 0);
        int_ack = 1;
        tick();
        int_ack = 0;
        tick(4);
        check("t1_idle_ack_ignored", busy, 0);

        // 2: simultaneous rises, lowest index first
        irq_in = 4'b1010;
        tick(2);
        check("t2_pending", pending, 4'b1010);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        check("t2_first_int", cpu_int, 1);
        irq_in = 0;
        serve();
        check("t2_gap_int", cpu_int, 0);
        check("t2_gap_busy", busy, 0);
        check("t2_gap_pending", pending, 4'b1000);
        tick();
        check("t2_second_int", cpu_int, 1);
        serve();

        // 3: masked source retained, fires on unmask
        mask_we = 1;
        mask_din = 4'b1110;
        tick();
        mask_we = 0;
        irq_in = 4'b0001;
        tick(2);
        check("t3_pending", pending, 4'b0001);
        irq_in = 0;
        tick(2);
        check("t3_masked_int", cpu_int, 0);
        check("t3_masked_busy", busy, 0);
        exp_q.push_back(0);
        mask_we = 1;
        mask_din = 4'b1111;
        tick();
        mask_we = 0;
        check("t3_unmask_lat", cpu_int, 0);
        tick();
        check("t3_unmask_int", cpu_int, 1);
        serve();
        check("t3_done_pending", pending, 0);

        // 4: stray eoi/ack handling and re-rise during CLEAR
        irq_in = 4'b0100;
        tick();
        irq_in = 0;
        exp_q.push_back(2);
        tick(2);
        check("t4_int", cpu_int, 1);
        eoi = 1;
        tick();
        eoi = 0;
        check("t4_eoi_in_req", cpu_int, 1);
        int_ack = 1;
        eoi = 1;
        tick();
        int_ack = 0;
        eoi = 0;
        check("t4_ack_eoi_int", cpu_int, 0);
        tick();
        check("t4_still_service", busy, 1);
        eoi = 1;
        irq_in = 4'b0100;
        exp_q.push_back(2);
        tick();
        eoi = 0;
        irq_in = 0;
        tick();
        check("t4_set_wins", pending, 4'b0100);
        check("t4_gap_int", cpu_int, 0);
        tick();
        check("t4_re_req", cpu_int, 1);
        serve();
        check("t4_done_pending", pending, 0);

        // 5: reset in SERVICE discards everything and restores the mask
        mask_we = 1;
        mask_din = 4'b0111;
        tick();
        mask_we = 0;
        irq_in = 4'b1010;
        exp_q.push_back(1);
        tick(3);
        check("t5_int", cpu_int, 1);
        int_ack = 1;
        tick();
        int_ack = 0;
        check("t5_pending", pending, 4'b1010);
        rst = 1;
        irq_in = 0;
        #1;
        check("t5_rst_int", cpu_int, 0);
        check("t5_rst_pending", pending, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_src", src_id, 0);
        tick();
        rst = 0;
        tick(5);
        check("t5_quiet", cpu_int, 0);
        irq_in = 4'b1000;
        exp_q.push_back(3);
        tick(3);
        check("t5_mask_restored", cpu_int, 1);
        irq_in = 0;
        serve();

        // 6: unacknowledged request
        irq_in = 4'b0010;
        tick();
        irq_in = 0;
        exp_q.push_back(1);
        tick(2);
        check("t6_int", cpu_int, 1);
`ifdef IRQ_TIMEOUT_EN
        cnt = 0;
        while (cpu_int && cnt < 100) begin
            cnt++;
            tick();
        end
        check("t6_req_cycles", cnt, 64);
        check("t6_tflag", timeout_flag, 1);
        check("t6_pending_kept", pending, 4'b0010);
        exp_q.push_back(1);
        tick();
        check("t6_retry", cpu_int, 1);
        mask_we = 1;
        mask_din = 4'b1111;
        tick();
        mask_we = 0;
        check("t6_tflag_clr", timeout_flag, 0);
`else
        tick(80);
        check("t6_waits", cpu_int, 1);
        check("t6_no_tflag", timeout_flag, 0);
`endif
        serve();
        tick(3);
        check("q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
